// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Multi-cycle memory-access stage between execute and writeback. It accepts
// one load or store at a time and drives a word-wide data-memory port with
// byte enables. It waits for the memory acknowledge, then returns
// aligned and extended load data together with the destination register.
//
// Ports
//   i_clk, i_rstd        clock, synchronous active-low reset
//   i_req_valid          execute presents an operation
//   o_req_ready          unit is idle and can accept an operation
//   i_op                 [3]=store, [2]=unsigned load, [1:0]=size
//                        (00 byte, 01 half, 11 word, 10 illegal)
//   i_addr, i_wdata, i_rd  byte address, right-aligned store data, load dest
//   o_mem_req/we/be/addr/wdata  data-memory request port (held during access)
//   i_mem_ack, i_mem_rdata      memory completion and read word
//   o_done               one-cycle completion pulse
//   o_ld_data, o_ld_wra  extended load data and reg_file write address
//                        (both zero for stores and errors)
//   o_err                with o_done: misaligned, illegal size or timeout
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rstd,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_rd,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_done,
    output logic [31:0] o_ld_data,
    output logic [4:0]  o_ld_wra,
    output logic        o_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_op;
    logic [1:0]  r_off;
    logic [4:0]  r_rd;
    logic [7:0]  r_cnt;

    logic        w_bad;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Select the addressed lane(s) of the read word and extend to 32 bits.
    function automatic logic [31:0] f_extract(input logic [3:0]  op,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        sh = rdata >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? rdata[31:16] : rdata[15:0];
        case (op[1:0])
            2'b00:   res = op[2] ? {24'd0, b} : 32'(b);
            2'b01:   res = op[2] ? {16'd0, h} : 32'(h);
            default: res = rdata;
        endcase
        return res;
    endfunction

    always_comb begin
        w_bad   = 1'b0;
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        case (i_op[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_bad   = i_addr[0];
                w_be    = 4'b0011 << i_addr[1:0];
                w_wdata = {2{i_wdata[15:0]}};
            end
            2'b10:   w_bad = 1'b1;
            default: w_bad = (i_addr[1:0] != 2'b00);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstd) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_off       <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            o_req_ready <= 1'b1;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_done      <= 1'b0;
            o_ld_data   <= '0;
            o_ld_wra    <= '0;
            o_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_done    <= 1'b0;
                    o_err     <= 1'b0;
                    o_ld_data <= '0;
                    o_ld_wra  <= '0;
                    if (i_req_valid) begin
                        r_op        <= i_op;
                        r_off       <= i_addr[1:0];
                        r_rd        <= i_rd;
                        r_cnt       <= '0;
                        o_req_ready <= 1'b0;
                        if (w_bad) begin
                            // Rejected without touching memory.
                            r_state <= S_RESP;
                            o_done  <= 1'b1;
                            o_err   <= 1'b1;
                        end else begin
                            r_state     <= S_ACCESS;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_op[3];
                            o_mem_be    <= w_be;
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_wdata <= w_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (i_mem_ack) begin
                        r_state     <= S_RESP;
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_be    <= '0;
                        o_mem_addr  <= '0;
                        o_mem_wdata <= '0;
                        o_done      <= 1'b1;
                        o_err       <= 1'b0;
                        o_ld_data   <= r_op[3] ? '0 : f_extract(r_op, r_off, i_mem_rdata);
                        o_ld_wra    <= r_op[3] ? '0 : r_rd;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        r_state     <= S_RESP;
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_be    <= '0;
                        o_mem_addr  <= '0;
                        o_mem_wdata <= '0;
                        o_done      <= 1'b1;
                        o_err       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    o_req_ready <= 1'b1;
                    o_done      <= 1'b0;
                    o_err       <= 1'b0;
                    o_ld_data   <= '0;
                    o_ld_wra    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstd;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        done;
    logic [31:0] ld_data;
    logic [4:0]  ld_wra;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rstd(rstd), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_op(op), .i_addr(addr), .i_wdata(wdata), .i_rd(rd),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_be(mem_be),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_done(done), .o_ld_data(ld_data), .o_ld_wra(ld_wra), .o_err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_bad(input logic [3:0] o, input logic [31:0] a);
        int sz = int'(o[1:0]);
        return (sz == 2) || (sz == 1 && (a % 2) != 0) || (sz == 3 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] o, input logic [31:0] a);
        int sz = int'(o[1:0]);
        if (sz == 0) return 4'(1 << (a % 4));
        if (sz == 1) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] o, input logic [31:0] d);
        int sz = int'(o[1:0]);
        if (sz == 0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] r);
        int sz = int'(o[1:0]);
        logic [31:0] v;
        if (sz == 0) begin
            v = (r >> ((a % 4) * 8)) & 32'hFF;
            if (!o[2] && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (r >> ((a & 2) * 8)) & 32'hFFFF;
            if (!o[2] && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    // Issue one operation; the memory acknowledges after wt wait cycles
    // (never, when wt >= TIMEOUT). Returns with the unit back in IDLE.
    task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] r,
                          input logic [31:0] rdat, input int wt);
        bit  bad = m_bad(o, a);
        bit  exp_err;
        int  cyc = 0;
        int  iters = 0;
        bit  got = 0;
        bit  stable = 1;
        int  exp_cyc;
        logic [31:0] exp_ld;
        logic [4:0]  exp_wra;

        check({nm, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; op = o; addr = a; wdata = d; rd = r;
        step();
        req_valid = 1'b0;
        op = 4'($urandom); addr = $urandom; wdata = $urandom; rd = 5'($urandom);

        if (bad) begin
            exp_err = 1'b1;
            check({nm, ".nomemreq"}, 32'(mem_req), 32'd0);
        end else begin
            check({nm, ".mem_addr"}, mem_addr, a & 32'hFFFFFFFC);
            check({nm, ".mem_be"}, 32'(mem_be), 32'(m_be(o, a)));
            check({nm, ".mem_we"}, 32'(mem_we), 32'(o[3]));
            if (o[3]) check({nm, ".mem_wdata"}, mem_wdata, m_wdata(o, d));
            for (int i = 0; i < 40; i++) begin
                if (done) begin got = 1; break; end
                if (mem_req) begin
                    cyc++;
                    if (mem_addr !== (a & 32'hFFFFFFFC) || mem_be !== m_be(o, a)) stable = 0;
                end
                mem_ack   = mem_req && (cyc == wt + 1);
                mem_rdata = mem_ack ? rdat : $urandom;
                step();
                mem_ack = 1'b0;
                iters++;
            end
            exp_err = (wt >= TIMEOUT);
            exp_cyc = exp_err ? TIMEOUT : wt + 1;
            check({nm, ".done_seen"}, 32'(got), 32'd1);
            check({nm, ".req_cycles"}, cyc, exp_cyc);
            check({nm, ".latency"}, iters, exp_cyc);
            check({nm, ".stable"}, 32'(stable), 32'd1);
        end

        exp_ld  = (exp_err || o[3]) ? 32'd0 : m_load(o, a, rdat);
        exp_wra = (exp_err || o[3]) ? 5'd0 : r;
        check({nm, ".done"}, 32'(done), 32'd1);
        check({nm, ".err"}, 32'(err), 32'(exp_err));
        check({nm, ".ld_data"}, ld_data, exp_ld);
        check({nm, ".ld_wra"}, 32'(ld_wra), 32'(exp_wra));
        check({nm, ".ready_resp"}, 32'(req_ready), 32'd0);
        // A stray ack outside ACCESS must have no effect.
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check({nm, ".done_drop"}, 32'(done), 32'd0);
        check({nm, ".wra_drop"}, 32'(ld_wra), 32'd0);
        check({nm, ".data_drop"}, ld_data, 32'd0);
        check({nm, ".idle_noreq"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        bit saw_done;
        logic [3:0] rop;
        logic [31:0] raddr;

        rstd = 1'b0; req_valid = 1'b0; op = '0; addr = '0; wdata = '0; rd = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.mem_be", 32'(mem_be), 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        rstd = 1'b1;
        step();

        run_op("lw",  4'b0011, 32'h104, 32'h0, 5'd7,  32'hDEADBEEF, 0);
        run_op("lb",  4'b0000, 32'h103, 32'h0, 5'd3,  32'h80FF1234, 1);
        run_op("lbu", 4'b0100, 32'h103, 32'h0, 5'd4,  32'h80FF1234, 0);
        run_op("lh",  4'b0001, 32'h102, 32'h0, 5'd5,  32'h80FF1234, 2);
        run_op("lhu", 4'b0101, 32'h102, 32'h0, 5'd6,  32'h80FF1234, 0);
        run_op("sb",  4'b1000, 32'h21,  32'hA5, 5'd9, 32'h0, 0);
        run_op("sh",  4'b1001, 32'h22,  32'h1234BEEF, 5'd9, 32'h0, 1);
        run_op("sw",  4'b1011, 32'h40,  32'hCAFEF00D, 5'd1, 32'h0, 0);
        run_op("lw_mis", 4'b0011, 32'h102, 32'h0, 5'd8, 32'h0, 0);
        run_op("lh_mis", 4'b0001, 32'h101, 32'h0, 5'd8, 32'h0, 0);
        run_op("ill",    4'b0010, 32'h100, 32'h0, 5'd8, 32'h0, 0);
        run_op("rd0",    4'b0011, 32'h200, 32'h0, 5'd0, 32'h12345678, 0);
        run_op("tmo",    4'b0011, 32'h300, 32'h0, 5'd2, 32'h11111111, TIMEOUT);
        run_op("ack16",  4'b0011, 32'h300, 32'h0, 5'd2, 32'h22222222, TIMEOUT - 1);

        // Reset in the middle of an access; a late ack must be ignored.
        req_valid = 1'b1; op = 4'b0011; addr = 32'h500; rd = 5'd10;
        step();
        req_valid = 1'b0;
        check("mrst.mem_req", 32'(mem_req), 32'd1);
        step(); step();
        rstd = 1'b0;
        step(); step();
        rstd = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            mem_ack = 1'b0;
            if (done) saw_done = 1;
        end
        check("mrst.mem_req_off", 32'(mem_req), 32'd0);
        check("mrst.no_done", 32'(saw_done), 32'd0);
        check("mrst.ready", 32'(req_ready), 32'd1);

        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom);
            raddr = $urandom;
            run_op("rnd", rop, raddr, $urandom, 5'($urandom), $urandom,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 17))
                                               : int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle memory-access stage directly downstream of execute and upstream of writeback/reg_file.
- Accepts one load/store request from execute, drives a word-wide data-memory port with byte enables, and waits for a memory acknowledge.
- Returns aligned, sign/zero-extended load data plus destination register; reports misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT, 16, max cycles mem_req stays high without mem_ack before the access aborts with err (legal range 2..255).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rstd  input  1  synchronous active-low reset
- req_valid  input  1  execute presents a memory operation
- req_ready  output  1  unit can accept a request this cycle
- op  input  4  op[3]=store, op[2]=unsigned (loads only), op[1:0]=size: 00 byte, 01 half, 11 word, 10 illegal
- addr  input  32  byte address (result of ALU rs+imm)
- wdata  input  32  store data (rt value), right-aligned
- rd  input  5  load destination register
- mem_req  output  1  memory access request
- mem_we  output  1  1=write, 0=read
- mem_be  output  4  byte enables, bit i = byte lane i (bits 8i+7:8i), little-endian
- mem_addr  output  32  word address: {addr[31:2],2'b00}
- mem_wdata  output  32  store data replicated into the addressed lanes
- mem_ack  input  1  memory completes access this cycle; mem_rdata valid for reads
- mem_rdata  input  32  read word
- done  output  1  one-cycle completion pulse
- ld_data  output  32  extended load data; 0 for stores and errors
- ld_wra  output  5  write address for reg_file; 0 for stores and errors (0 = no write)
- err  output  1  with done: misaligned, illegal size, or timeout

Behaviour:
- Reset (rstd=0 at a clk edge): state IDLE; req_ready=1; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, done=0, ld_data=0, ld_wra=0, err=0, timeout counter=0. Applies mid-access: an in-flight access is dropped, no done pulse; a mem_ack arriving after reset is ignored.
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid: latch op, addr[1:0], wdata, rd. If size==10, or half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with err=1, no memory cycle. Else -> ACCESS, mem_req=1 from the next cycle, mem_addr/mem_we/mem_be/mem_wdata registered in the same edge.
- Byte enables: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0] (addr[1]=0 or 1 only); word -> 4'b1111. Loads drive the same mem_be (informational).
- mem_wdata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
- ACCESS: req_ready=0; mem_req and all mem_* outputs held stable until mem_ack. Counter increments each ACCESS cycle without mem_ack. On mem_ack: mem_req=0 next cycle, capture mem_rdata, -> RESP. If counter reaches TIMEOUT with no ack -> mem_req=0, -> RESP with err=1. mem_ack in the same cycle the counter hits TIMEOUT: ack wins, no err.
- Load extraction: byte = mem_rdata lane addr[1:0]; half = lane pair addr[1]; sign-extend from bit 7/15 when op[2]=0, zero-extend when op[2]=1. Word ignores op[2].
- RESP: done=1, err as determined, ld_data/ld_wra valid for exactly this cycle; req_ready=0; -> IDLE. done, ld_wra, ld_data return to 0 the following cycle.
- Minimum latency: request accepted at edge N, mem_req high after N, ack in the same cycle -> done in cycle after N+1. Back-to-back: new request accepted in IDLE the cycle after done; throughput one op per 3 cycles at zero wait states.
- mem_ack outside ACCESS is ignored. req_valid while req_ready=0 is ignored (execute must hold until accepted).
- rd=0 load completes normally with ld_wra=0.

Test Plan:
- Reset: hold rstd=0 two cycles mid-ACCESS with mem_ack=1 on following cycle -> mem_req=0, done never pulses, req_ready=1.
- LW addr=0x104, mem_rdata=0xDEADBEEF, ack after 0 wait -> mem_addr=0x104, mem_be=1111, done one cycle, ld_data=0xDEADBEEF, ld_wra=rd.
- LB addr=0x103 and LBU addr=0x103, rdata=0x80FF1234 -> mem_be=1000; ld_data=0xFFFFFF80 then 0x00000080; LH addr=0x102 -> 0xFFFF80FF.
- SB addr=0x21, wdata=0x000000A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5A5A5; SH addr=0x22 -> mem_be=1100; done with ld_wra=0.
- Misaligned LW addr=0x102 and op size 10 -> no mem_req, done with err=1 next cycle, ld_wra=0.
- Timeout: TIMEOUT=16, never ack -> mem_req high exactly 16 cycles, done+err=1; repeat with ack on cycle 16 -> err=0.
